// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   - FSM state encodings (2-bit; 2'b11 is unused and recovers to IDLE)
//   - Default burst length used when the top-level parameter is not overridden
package arb_pkg;

  // Arbiter states. Kept as plain localparams so older tools and
  // netlist-level debug see stable, known bit patterns.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_A = 2'b01;
  localparam logic [1:0] GNT_B = 2'b10;

  // Default maximum consecutive grant cycles per requester.
  localparam int ARB_BURST_DEFAULT = 4;

endpackage

// File: rtl/burst_counter.sv
// Hold counter that measures how long the current owner has held the bus.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (clears the count)
//   i_clr    : synchronous clear, wins over increment
//   i_inc    : advance the count by one
//   o_expire : count has reached BURST-1, i.e. this is the owner's last cycle
module burst_counter #(
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [CW-1:0] LIMIT = CW'(BURST - 1);

  logic [CW-1:0] r_cnt;

  // The count saturates at LIMIT rather than wrapping; the arbiter always
  // clears or re-grants on expiry, so saturation is only a safety net.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/mux2.sv
// Two-input WIDTH-bit multiplexer shared by the bus masters.
// Ports:
//   i_a  : data routed to o_y when i_s = 0
//   i_b  : data routed to o_y when i_s = 1
//   i_s  : select
//   o_y  : selected data (purely combinational)
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_s ? i_b : i_a;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a shared mux.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   req_a, req_b   : bus requests from masters A and B
//   data_a, data_b : master data, WIDTH bits each
//   gnt_a, gnt_b   : registered grants, never both high
//   sel            : registered mux select (0 = A, 1 = B), holds while idle
//   q              : shared bus data, combinational through the mux
//   valid          : some master owns the bus this cycle
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = ARB_BURST_DEFAULT,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [1:0] r_state;
  logic       r_last;
  logic       r_sel;

  logic [1:0] w_nextState;
  logic       w_nextLast;
  logic       w_nextSel;
  logic       w_cntClr;
  logic       w_cntInc;
  logic       w_expire;

  // Hold counter for the current owner's burst.
  burst_counter #(
    .BURST (BURST),
    .CW    (CW)
  ) u_burstCounter (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cntClr),
    .i_inc    (w_cntInc),
    .o_expire (w_expire)
  );

  // Next-state logic. The counter is cleared on every path except
  // "owner keeps requesting and has budget left", so any fresh grant or
  // re-grant starts from zero. last records who just gave up (or
  // re-earned) the bus, and only matters for ties seen from IDLE.
  always_comb begin
    w_nextState = IDLE;
    w_nextLast  = r_last;
    w_cntClr    = 1'b1;
    w_cntInc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) begin
          w_nextState = r_last ? GNT_A : GNT_B;
        end else if (req_a) begin
          w_nextState = GNT_A;
        end else if (req_b) begin
          w_nextState = GNT_B;
        end else begin
          w_nextState = IDLE;
        end
      end
      GNT_A: begin
        if (req_a && !w_expire) begin
          w_nextState = GNT_A;
          w_cntClr    = 1'b0;
          w_cntInc    = 1'b1;
        end else begin
          w_nextLast = 1'b0;
          if (req_b) begin
            w_nextState = GNT_B;
          end else if (req_a) begin
            w_nextState = GNT_A;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      GNT_B: begin
        if (req_b && !w_expire) begin
          w_nextState = GNT_B;
          w_cntClr    = 1'b0;
          w_cntInc    = 1'b1;
        end else begin
          w_nextLast = 1'b1;
          if (req_a) begin
            w_nextState = GNT_A;
          end else if (req_b) begin
            w_nextState = GNT_B;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The select follows the owner, but keeps its last value while idle so
  // the shared bus does not toggle when nobody is using it.
  always_comb begin
    w_nextSel = r_sel;
    if (w_nextState == GNT_A) begin
      w_nextSel = 1'b0;
    end else if (w_nextState == GNT_B) begin
      w_nextSel = 1'b1;
    end
  end

  // State, priority and select registers. Reset drops any burst in
  // flight immediately and hands the first tie to A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
      r_sel   <= w_nextSel;
    end
  end

  assign gnt_a = (r_state == GNT_A);
  assign gnt_b = (r_state == GNT_B);
  assign valid = gnt_a | gnt_b;
  assign sel   = r_sel;

  // Shared datapath through the existing mux.
  mux2 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_a (data_a),
    .i_b (data_b),
    .i_s (r_sel),
    .o_y (q)
  );

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle
// against an ownership/run-length model of the arbitration rules.
module tb_rr_bus_arbiter;

  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic             reqA;
  logic             reqB;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             gntA;
  logic             gntB;
  logic             sel;
  logic [WIDTH-1:0] q;
  logic             valid;

  int vectors = 0;
  int errors  = 0;
  int cycle   = 0;

  // Model: who owns the bus (0 none, 1 A, 2 B), how many consecutive
  // cycles it has held it, who gave it up last (0 A, 1 B), and the select.
  int   mOwner = 0;
  int   mRun   = 0;
  int   mLast  = 1;
  logic mSel   = 1'b0;
  logic mine;
  logic theirs;

  rr_bus_arbiter #(
    .WIDTH (WIDTH),
    .BURST (BURST),
    .CW    (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (reqA),
    .req_b  (reqB),
    .data_a (dataA),
    .data_b (dataB),
    .gnt_a  (gntA),
    .gnt_b  (gntB),
    .sel    (sel),
    .q      (q),
    .valid  (valid)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, advanced on every rising edge from the inputs that
  // were settled during the previous cycle.
  always @(posedge clk) begin
    cycle++;
    if (rst) begin
      mOwner = 0;
      mRun   = 0;
      mLast  = 1;
      mSel   = 1'b0;
    end else begin
      if (mOwner == 0) begin
        if (reqA && reqB)  mOwner = (mLast == 1) ? 1 : 2;
        else if (reqA)     mOwner = 1;
        else if (reqB)     mOwner = 2;
        if (mOwner != 0)   mRun = 1;
      end else begin
        mine   = (mOwner == 1) ? reqA : reqB;
        theirs = (mOwner == 1) ? reqB : reqA;
        if (mine && mRun < BURST) begin
          mRun++;
        end else begin
          mLast = mOwner - 1;
          if (theirs) begin
            mOwner = 3 - mOwner;
            mRun   = 1;
          end else if (mine) begin
            mRun = 1;
          end else begin
            mOwner = 0;
            mRun   = 0;
          end
        end
      end
      if (mOwner == 1)      mSel = 1'b0;
      else if (mOwner == 2) mSel = 1'b1;
    end
  end

  // One comparison, counted, with a FAIL line on mismatch.
  task automatic compareField(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, a little after
  // each rising edge so the registered outputs have settled.
  always @(posedge clk) begin
    #3;
    compareField("model_gnt_a", WIDTH'(gntA),  WIDTH'(mOwner == 1));
    compareField("model_gnt_b", WIDTH'(gntB),  WIDTH'(mOwner == 2));
    compareField("model_valid", WIDTH'(valid), WIDTH'(mOwner != 0));
    compareField("model_sel",   WIDTH'(sel),   WIDTH'(mSel));
    compareField("model_q",     q,             mSel ? dataB : dataA);
  end

  // Drive all inputs at once, away from the clock edge.
  task automatic applyStimulus(input logic r, input logic a, input logic b,
                               input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    rst   = r;
    reqA  = a;
    reqB  = b;
    dataA = da;
    dataB = db;
  endtask

  // Let one edge pass, then check DUT and model against hand-worked values.
  task automatic checkOutput(input string name, input logic eGa, input logic eGb,
                             input logic eSel, input logic [WIDTH-1:0] eQ);
    int eOwner;
    @(posedge clk);
    #1;
    eOwner = eGa ? 1 : (eGb ? 2 : 0);
    compareField({name, "_gnt_a"}, WIDTH'(gntA),  WIDTH'(eGa));
    compareField({name, "_gnt_b"}, WIDTH'(gntB),  WIDTH'(eGb));
    compareField({name, "_valid"}, WIDTH'(valid), WIDTH'(eGa | eGb));
    compareField({name, "_sel"},   WIDTH'(sel),   WIDTH'(eSel));
    compareField({name, "_q"},     q,             eQ);
    compareField({name, "_model"}, WIDTH'(mOwner), WIDTH'(eOwner));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;

    // Reset for two edges, then a tie: A must win first.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
    checkOutput("reset1", 1'b0, 1'b0, 1'b0, 8'h11);
    checkOutput("reset2", 1'b0, 1'b0, 1'b0, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 8'h44);
    checkOutput("tieA",   1'b1, 1'b0, 1'b0, 8'h33);

    // Held contention: four A cycles, four B cycles, back to A, no bubble.
    checkOutput("burstA2", 1'b1, 1'b0, 1'b0, 8'h33);
    checkOutput("burstA3", 1'b1, 1'b0, 1'b0, 8'h33);
    checkOutput("burstA4", 1'b1, 1'b0, 1'b0, 8'h33);
    for (int i = 0; i < BURST; i++) checkOutput("burstB", 1'b0, 1'b1, 1'b1, 8'h44);
    checkOutput("burstA5", 1'b1, 1'b0, 1'b0, 8'h33);

    // Everyone drops: idle with select held at A.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h33, 8'h44);
    checkOutput("idle1", 1'b0, 1'b0, 1'b0, 8'h33);

    // Lone B request, then B drops: select stays on B while idle.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h5A);
    checkOutput("loneB", 1'b0, 1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A);
    checkOutput("idleHoldB", 1'b0, 1'b0, 1'b1, 8'h5A);

    // Only A requests for ten cycles: continuous grant via re-grants.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 8'h5A);
    for (int i = 0; i < 10; i++) checkOutput("regrantA", 1'b1, 1'b0, 1'b0, 8'h77);

    // A was re-granted on expiry, so A counts as served last: next tie goes to B.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h77, 8'h5A);
    checkOutput("idle2", 1'b0, 1'b0, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 8'h5A);
    checkOutput("tieB", 1'b0, 1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < BURST - 1; i++) checkOutput("holdB", 1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("earlyA1", 1'b1, 1'b0, 1'b0, 8'h77);
    checkOutput("earlyA2", 1'b1, 1'b0, 1'b0, 8'h77);

    // A releases after two cycles: B takes over at the very next edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 8'h5A);
    checkOutput("earlyRelB", 1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("midB1",     1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("midB2",     1'b0, 1'b1, 1'b1, 8'h5A);

    // Reset in the middle of B's burst, then a tie goes to A again.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB);
    checkOutput("midRst", 1'b0, 1'b0, 1'b0, 8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hAA, 8'hBB);
    checkOutput("postRstTieA", 1'b1, 1'b0, 1'b0, 8'hAA);

    // Randomized traffic: requests are sticky-ish, occasional resets,
    // fresh data every cycle. The every-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0),
                    WIDTH'($urandom), WIDTH'($urandom));
    end
    @(posedge clk);
    #5;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
Two-requester round-robin arbiter that shares one WIDTH-bit datapath through the existing 2-input mux. It sequences the mux select line so that only the granted requester's data reaches q. A burst limit prevents either requester from holding the path indefinitely. It sits between two bus masters (e.g. fetch and load/store) and a shared downstream bus.

Parameters:
WIDTH, 8, data width of each requester's data and of q
BURST, 4, max consecutive granted cycles per requester before forced re-arbitration; legal range 1..16
CW, 4, hold-counter width; must satisfy 2^CW >= BURST

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_a  in  1  requester A wants the bus
req_b  in  1  requester B wants the bus
data_a  in  WIDTH  requester A data
data_b  in  WIDTH  requester B data
gnt_a  out  1  A owns the bus this cycle
gnt_b  out  1  B owns the bus this cycle
sel  out  1  mux select: 0 = A, 1 = B
q  out  WIDTH  shared bus data: data_a when sel=0, data_b when sel=1
valid  out  1  gnt_a | gnt_b

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the rising clk edge.
- State register values: IDLE, GNT_A, GNT_B. Other registers: hold counter cnt[CW-1:0] and priority bit last (0 = A served last, 1 = B served last).
- Reset, taking effect at the next edge including mid-burst:
  - state=IDLE, cnt=0, last=1 (A wins the first tie), sel=0.
  - Resulting outputs: gnt_a=0, gnt_b=0, valid=0, q=data_a.
- gnt_a = (state==GNT_A) and gnt_b = (state==GNT_B). Both are decoded from registers and never both 1.
- sel is registered. It is 1 in GNT_B and 0 in GNT_A. In IDLE it holds its previous value, so there is no needless toggle.
- q is purely combinational through the mux. It has zero latency from data_x and from sel.
- Latency: a request sampled high at edge N produces a grant at edge N (visible from N to N+1) when the arbiter is IDLE.
- IDLE transitions:
  - Both requesting: grant the one with !last.
  - One requesting: grant it.
  - None requesting: stay in IDLE.
  - Any entry into GNT_x sets cnt=0.
- GNT_x, with y the other requester. Let expire = (cnt == BURST-1).
  - req_x=1 and !expire: stay in GNT_x, cnt++.
  - req_x=0 or expire, with req_y=1: go directly to GNT_y with no idle bubble; cnt=0, last=x.
  - expire, req_x=1, req_y=0: re-grant x; stay in GNT_x, cnt=0, last=x.
  - req_x=0, req_y=0: go to IDLE, last=x.
- Release overhang: a requester that drops req at edge N stays granted until edge N. The requester must treat the cycle after its last driven data as ignored. Verification checks that gnt drops exactly one edge after req falls.
- BURST=1: under continuous dual requests, grants strictly alternate A,B,A,B every cycle.
- cnt never exceeds BURST-1 and does not wrap. If req_x stays high while req_y is high, the switch at expiry is mandatory.
- Simultaneous req edges arriving while IDLE are resolved by last only.
- Reset asserted while granted: grants deassert at that edge. In-flight bursts are abandoned without any drain.

Decomposition:
- Shared package (arb_pkg):
  - State encoding constants: IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10. 2'b11 is illegal and decodes to IDLE at the next edge.
  - Constant ARB_BURST_DEFAULT=4.
- Natural sub-module: burst_counter. It is a CW-bit synchronous counter with a clear input, an increment input, and an expire compare against BURST-1.
- The datapath reuses the existing mux with WIDTH passed through. sel drives its s input.
- The top level holds only the next-state logic, the last and sel registers, and the grant decode.

Test Plan:
- Reset priority: rst=1 for 2 cycles, then req_a=req_b=1 at the same edge -> gnt_a=1 first, sel=0, valid=1.
- Lone requester: req_b=1 from IDLE with data_b=8'h5A -> gnt_b=1 and sel=1 at the next edge, q=8'h5A; A stays ungranted.
- Burst expiry under contention: BURST=4, req_a=req_b=1 held -> grant sequence A,A,A,A,B,B,B,B,A…, with no idle cycle at switches.
- Re-grant without contention: only req_a=1 for 10 cycles -> gnt_a held continuously, cnt cycles 0..3, last ends at 0.
- Early release: A granted, req_a drops after 2 cycles while req_b=1 -> gnt_b=1 one edge after req_a falls, before expiry.
- Reset mid-burst: rst=1 during GNT_B cnt=2 -> next edge gives gnt_a=gnt_b=0, sel=0, q=data_a; after release, a tie grants A.
